mips_fetch_queue: RTL and testbench

MIPS_FETCH_QUEUE -- requirements
Module: mips_fetch_queue

---
 rtl/mips_fetch_queue.sv | 139 +++++++++++++
 tb/tb_mips_fetch_queue.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_fetch_queue.sv
// Instruction fetch queue: one outstanding imem read, FWFT instruction queue,
// branch redirect with stale-response discard, and fetch halt on HLT.
//
// state   | meaning
// IDLE    | no request outstanding; issue one when the queue has room
// WAIT    | request outstanding; an ack pushes the word
// DISCARD | request outstanding but redirected; the ack is dropped
// STOP    | HLT enqueued; no fetching until a branch redirect
module mips_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk1,
    input  logic        rst,
    output logic        imem_req,
    output logic [9:0]  imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_ir,
    output logic [31:0] out_npc,
    output logic        fetch_stopped
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DISCARD, STOP} state_t;

    state_t          state, state_nxt;
    logic [31:0]     pc, pc_nxt, pc_inc;
    logic [CW-1:0]   count, count_nxt, count_post;
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [31:0]     ir_mem  [DEPTH];
    logic [31:0]     npc_mem [DEPTH];
    logic            push, pop, is_hlt, stop_nxt, addr_hold;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign pc_inc     = pc + 32'd1;
    assign is_hlt     = (imem_rdata[31:26] == 6'b111111);
    assign push       = (state == WAIT) && imem_ack && !br_taken;
    assign pop        = out_valid && out_ready && !br_taken;
    assign count_post = count + CW'(push) - CW'(pop);
    // The address of an outstanding request must not move until its ack.
    assign addr_hold  = (state == WAIT || state == DISCARD) && !imem_ack;

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        stop_nxt  = fetch_stopped;
        case (state)
            IDLE: begin
                if (br_taken)
                    pc_nxt = br_target;
                else if (count < CW'(DEPTH))
                    state_nxt = WAIT;
            end
            WAIT: begin
                if (br_taken) begin
                    pc_nxt    = br_target;
                    state_nxt = imem_ack ? IDLE : DISCARD;
                end else if (imem_ack) begin
                    pc_nxt = pc_inc;
                    if (is_hlt) begin
                        state_nxt = STOP;
                        stop_nxt  = 1'b1;
                    end else if (count_post >= CW'(DEPTH)) begin
                        state_nxt = IDLE;
                    end
                end
            end
            DISCARD: begin
                if (br_taken)
                    pc_nxt = br_target;
                if (imem_ack)
                    state_nxt = IDLE;
            end
            STOP: begin
                if (br_taken) begin
                    pc_nxt    = br_target;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (br_taken)
            stop_nxt = 1'b0;
        count_nxt = br_taken ? '0 : count_post;
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            pc            <= RESET_PC;
            count         <= '0;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            imem_req      <= 1'b0;
            imem_addr     <= RESET_PC[9:0];
            fetch_stopped <= 1'b0;
        end else begin
            state         <= state_nxt;
            pc            <= pc_nxt;
            count         <= count_nxt;
            fetch_stopped <= stop_nxt;
            imem_req      <= (state_nxt == WAIT) || (state_nxt == DISCARD);
            if (!addr_hold)
                imem_addr <= pc_nxt[9:0];
            if (br_taken) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push)
                    wr_ptr <= ptr_inc(wr_ptr);
                if (pop)
                    rd_ptr <= ptr_inc(rd_ptr);
            end
        end
    end

    always_ff @(posedge clk1) begin
        if (push) begin
            ir_mem[wr_ptr]  <= imem_rdata;
            npc_mem[wr_ptr] <= pc_inc;
        end
    end

    // Head is gated by valid so a flushed entry is never visible.
    assign out_valid = (count != '0);
    assign out_ir    = out_valid ? ir_mem[rd_ptr]  : 32'h0;
    assign out_npc   = out_valid ? npc_mem[rd_ptr] : 32'h0;

endmodule

// File: tb/tb_mips_fetch_queue.sv
// Bench for mips_fetch_queue: fill/drain vector table, redirect/HLT/reset
// sequences, and a long random run against a transaction-level queue model.
module tb_mips_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk1 = 1'b0;
    logic        rst  = 1'b1;
    logic        imem_req;
    logic [9:0]  imem_addr;
    logic        imem_ack   = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        br_taken   = 1'b0;
    logic [31:0] br_target  = 32'h0;
    logic        out_valid;
    logic        out_ready  = 1'b0;
    logic [31:0] out_ir;
    logic [31:0] out_npc;
    logic        fetch_stopped;

    always #5 clk1 = ~clk1;

    mips_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk1(clk1), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .br_taken(br_taken), .br_target(br_target),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ir(out_ir), .out_npc(out_npc),
        .fetch_stopped(fetch_stopped)
    );

    int checks = 0;
    int errors = 0;

    // memory responder state
    int   lat      = 0;
    int   cnt      = 0;
    bit   prev_ack = 1'b0;
    bit   spur_en  = 1'b0;
    bit   hlt_en   = 1'b0;
    bit   rnd_hlt  = 1'b0;
    logic [9:0] hlt_addr = 10'h0;

    // reference model state
    logic [63:0] mq[$];
    logic [31:0] nf;
    bit          m_stop, stale, m_prev_req, m_prev_ackd, m_prev_br;
    logic [9:0]  m_prev_addr;
    int          idle_run;

    typedef struct {
        bit          rdy;
        bit          v;
        logic [31:0] ir;
        logic [31:0] npc;
        bit          req;
        logic [31:0] addr;
    } vec_t;
    vec_t tbl[12];

    function automatic logic [31:0] memw(input logic [9:0] a);
        if (hlt_en && a == hlt_addr) return 32'hFC00_0000;
        if (rnd_hlt && (a % 37) == 5) return 32'hFC00_0000 | 32'(a);
        return 32'h1000_0000 + 32'(a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, {31'h0, act}, {31'h0, exp});
    endtask

    task automatic respond();
        if (imem_req) begin
            if (prev_ack) cnt = 0;
            if (cnt >= lat) begin
                imem_ack   = 1'b1;
                imem_rdata = memw(imem_addr);
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = 32'h0;
                cnt++;
            end
        end else begin
            cnt        = 0;
            imem_ack   = spur_en && ($urandom_range(0, 4) == 0);
            imem_rdata = $urandom;
        end
        prev_ack = imem_req && imem_ack;
    endtask

    task automatic step();
        @(posedge clk1);
        #1;
        br_taken = 1'b0;
        respond();
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        br_taken  = 1'b0;
        imem_ack  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk1);
        #1;
        chk1("rst_req", imem_req, 1'b0);
        chk("rst_addr", 32'(imem_addr), RESET_PC & 32'h3FF);
        chk1("rst_valid", out_valid, 1'b0);
        chk("rst_ir", out_ir, 32'h0);
        chk("rst_npc", out_npc, 32'h0);
        chk1("rst_stop", fetch_stopped, 1'b0);
        prev_ack = 1'b0;
        cnt      = 0;
        rst      = 1'b0;
    endtask

    initial begin
        // zero-wait fetch of Mem[0..], stream then backpressure to fill
        tbl[0]  = '{1'b1, 1'b0, 32'h0,         32'd0, 1'b1, 32'h0};
        tbl[1]  = '{1'b1, 1'b1, 32'h1000_0000, 32'd1, 1'b1, 32'h1};
        tbl[2]  = '{1'b1, 1'b1, 32'h1000_0001, 32'd2, 1'b1, 32'h2};
        tbl[3]  = '{1'b0, 1'b1, 32'h1000_0002, 32'd3, 1'b1, 32'h3};
        tbl[4]  = '{1'b0, 1'b1, 32'h1000_0002, 32'd3, 1'b1, 32'h4};
        tbl[5]  = '{1'b0, 1'b1, 32'h1000_0002, 32'd3, 1'b1, 32'h5};
        tbl[6]  = '{1'b0, 1'b1, 32'h1000_0002, 32'd3, 1'b0, 32'h6};
        tbl[7]  = '{1'b1, 1'b1, 32'h1000_0002, 32'd3, 1'b0, 32'h6};
        tbl[8]  = '{1'b0, 1'b1, 32'h1000_0003, 32'd4, 1'b0, 32'h6};
        tbl[9]  = '{1'b0, 1'b1, 32'h1000_0003, 32'd4, 1'b1, 32'h6};
        tbl[10] = '{1'b0, 1'b1, 32'h1000_0003, 32'd4, 1'b0, 32'h7};
        tbl[11] = '{1'b0, 1'b1, 32'h1000_0003, 32'd4, 1'b0, 32'h7};

        do_reset();
        lat = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            chk1($sformatf("tbl%0d_valid", i), out_valid, tbl[i].v);
            chk($sformatf("tbl%0d_ir", i), out_ir, tbl[i].ir);
            chk($sformatf("tbl%0d_npc", i), out_npc, tbl[i].npc);
            chk1($sformatf("tbl%0d_req", i), imem_req, tbl[i].req);
            chk($sformatf("tbl%0d_addr", i), 32'(imem_addr), tbl[i].addr);
            chk1($sformatf("tbl%0d_stop", i), fetch_stopped, 1'b0);
            out_ready = tbl[i].rdy;
        end

        // redirect while waiting on a 3-cycle memory
        do_reset();
        lat = 3;
        out_ready = 1'b1;
        step();
        step();
        br_taken  = 1'b1;
        br_target = 32'h40;
        step();
        chk1("dis_req", imem_req, 1'b1);
        chk("dis_addr_held", 32'(imem_addr), 32'h0);
        chk1("dis_valid", out_valid, 1'b0);
        step();
        step();
        chk1("dis_dropped", out_valid, 1'b0);
        chk("dis_next_addr", 32'(imem_addr), 32'h040);
        for (int k = 0; k < 20 && !out_valid; k++) step();
        chk1("br_first_valid", out_valid, 1'b1);
        chk("br_first_ir", out_ir, 32'h1000_0040);
        chk("br_first_npc", out_npc, 32'h41);

        // HLT stops fetching, redirect resumes
        do_reset();
        lat = 0;
        hlt_en = 1'b1;
        hlt_addr = 10'd2;
        step();
        step();
        step();
        step();
        chk1("hlt_stop", fetch_stopped, 1'b1);
        chk1("hlt_noreq", imem_req, 1'b0);
        chk("hlt_head", out_ir, 32'h1000_0000);
        repeat (3) step();
        chk1("hlt_still_noreq", imem_req, 1'b0);
        out_ready = 1'b1;
        step();
        chk("hlt_pop1", out_ir, 32'h1000_0001);
        step();
        chk("hlt_word", out_ir, 32'hFC00_0000);
        chk("hlt_word_npc", out_npc, 32'd3);
        out_ready = 1'b0;
        br_taken  = 1'b1;
        br_target = 32'h10;
        step();
        chk1("hlt_clear", fetch_stopped, 1'b0);
        chk1("hlt_flush", out_valid, 1'b0);
        step();
        chk1("hlt_resume_req", imem_req, 1'b1);
        chk("hlt_resume_addr", 32'(imem_addr), 32'h010);
        hlt_en = 1'b0;

        // push+pop keeps count, then flush on ack+pop cycle
        do_reset();
        lat = 0;
        step();
        step();
        step();
        step();
        out_ready = 1'b1;
        step();
        chk1("pp_req", imem_req, 1'b1);
        chk("pp_addr", 32'(imem_addr), 32'h4);
        chk("pp_head", out_ir, 32'h1000_0001);
        chk("pp_npc", out_npc, 32'd2);
        br_taken  = 1'b1;
        br_target = 32'h20;
        step();
        chk1("fl_valid", out_valid, 1'b0);
        chk1("fl_req", imem_req, 1'b0);
        chk("fl_addr", 32'(imem_addr), 32'h020);
        step();
        chk1("fl_req2", imem_req, 1'b1);
        chk1("fl_valid2", out_valid, 1'b0);
        step();
        chk1("fl_valid3", out_valid, 1'b1);
        chk("fl_ir", out_ir, 32'h1000_0020);
        chk("fl_npc", out_npc, 32'h21);

        // reset mid-request, late ack ignored
        do_reset();
        lat = 5;
        step();
        step();
        chk1("rw_req", imem_req, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        chk1("rw_async_req", imem_req, 1'b0);
        imem_ack   = 1'b1;
        imem_rdata = 32'hFC00_0000;
        repeat (2) @(posedge clk1);
        #1;
        rst = 1'b0;
        @(posedge clk1);
        #1;
        chk1("rw_req_after", imem_req, 1'b1);
        chk("rw_addr_after", 32'(imem_addr), RESET_PC & 32'h3FF);
        chk1("rw_stop", fetch_stopped, 1'b0);
        chk1("rw_valid", out_valid, 1'b0);
        lat = 0;
        prev_ack = 1'b0;
        cnt = 0;
        respond();
        step();
        chk1("rw_first_valid", out_valid, 1'b1);
        chk("rw_first_ir", out_ir, 32'h1000_0000);
        chk("rw_first_npc", out_npc, 32'd1);

        // randomized run against the queue model
        do_reset();
        spur_en = 1'b1;
        rnd_hlt = 1'b1;
        lat = 1;
        nf = RESET_PC;
        mq.delete();
        m_stop = 1'b0;
        stale = 1'b0;
        m_prev_req = 1'b0;
        m_prev_ackd = 1'b0;
        m_prev_br = 1'b0;
        m_prev_addr = 10'h0;
        idle_run = 0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 49) == 0) lat = $urandom_range(0, 3);
            step();
            chk1("rnd_valid", out_valid, mq.size() != 0);
            if (mq.size() != 0) begin
                chk("rnd_ir", out_ir, mq[0][63:32]);
                chk("rnd_npc", out_npc, mq[0][31:0]);
            end
            chk1("rnd_stop", fetch_stopped, m_stop);
            if (m_stop || mq.size() >= DEPTH)
                chk1("rnd_noreq", imem_req, 1'b0);
            if (m_prev_req && !m_prev_ackd && imem_req)
                chk("rnd_hold", 32'(imem_addr), 32'(m_prev_addr));
            idle_run = (!imem_req && !m_stop && mq.size() < DEPTH && !m_prev_br) ? idle_run + 1 : 0;
            checks++;
            if (idle_run > 2) begin
                errors++;
                $display("FAIL rnd_progress idle_cycles=%0d limit=2 at %0t", idle_run, $time);
            end

            out_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 39) == 0) begin
                br_taken  = 1'b1;
                br_target = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFE : 32'($urandom_range(0, 300));
            end

            m_prev_req  = imem_req;
            m_prev_ackd = imem_req && imem_ack;
            m_prev_addr = imem_addr;
            m_prev_br   = br_taken;
            if (br_taken) begin
                mq.delete();
                nf     = br_target;
                m_stop = 1'b0;
                stale  = imem_req && !imem_ack;
            end else begin
                if (out_valid && out_ready && mq.size() != 0) void'(mq.pop_front());
                if (imem_req && imem_ack) begin
                    if (stale) begin
                        stale = 1'b0;
                    end else begin
                        chk("rnd_addr", 32'(imem_addr), nf & 32'h3FF);
                        mq.push_back({imem_rdata, nf + 32'd1});
                        if (imem_rdata[31:26] == 6'h3F) m_stop = 1'b1;
                        nf = nf + 32'd1;
                    end
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
